uart_rx_frontend: RTL and testbench
===================================

// Module: uart_rx_frontend
// PURPOSE
//  - UART byte receiver. Sits between the uart_rxd pad and the MCU's byte-level
//    command parser.
//  - Turns the asynchronous 8N1 serial line into validated bytes with a
//    valid/ready handshake.
//  - Reports framing and overrun errors, and a busy flag for the LED/debug pins.
// PARAMETERS
//  CLK_FREQ  50_000_000  system clock frequency in Hz
//  BAUD      115200      line rate in bit/s
//  BIT_CNT   CLK_FREQ/BAUD (localparam, truncated): clocks per bit; 434 at defaults; must be >=16
//  HALF      BIT_CNT/2 (localparam): mid-bit sample point; 217 at defaults
// PORTS
//  sys_clk     in   1  system clock, all logic rising-edge
//  sys_rst_n   in   1  asynchronous reset, active low
//  uart_rxd    in   1  serial input, idle high, asynchronous to sys_clk
//  rx_data     out  8  received byte, LSB first on the line
//  rx_valid    out  1  rx_data holds an unconsumed byte
//  rx_ready    in   1  consumer accepts rx_data when rx_valid&&rx_ready
//  frame_err   out  1  1-cycle pulse: stop bit sampled low
//  overrun     out  1  1-cycle pulse: byte completed while holding register full
//  parity_err  out  1  1-cycle pulse: parity mismatch (only with UART_RX_PARITY_EN, else tied 0)
//  busy        out  1  high whenever the FSM is not in IDLE
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
//    Synchronizer flops reset to 1; FSM goes to IDLE.
//  - Reset asserted mid-frame aborts the frame immediately; no partial byte is kept.
//  - uart_rxd passes through a 2-flop synchronizer; rxs is the synchronized signal.
//  - Bit timer counts 0..BIT_CNT-1 and restarts at 0 at each bit boundary.
//  - Each bit is sampled at timer HALF-1, HALF and HALF+1; the bit value is the
//    2-of-3 majority, decided at HALF+1.
//  - IDLE: a 1->0 transition on rxs -> START, timer=0.
//  - START: majority=1 -> false start, back to IDLE, no output or flags.
//    Majority=0 -> DATA, bit index=0.
//  - DATA: 8 bits shifted in LSB first. After bit 7 -> PARITY if the macro is
//    defined, else -> STOP.
//  - STOP, stop bit=1: byte complete; FSM returns to IDLE at the decision cycle
//    (not at bit end), so back-to-back frames are caught.
//  - STOP, stop bit=0: frame_err pulses and the byte is dropped. FSM -> BRK,
//    then waits for rxs=1 before entering IDLE.
//  - Latency: rx_valid rises 1 clk after the stop-bit decision cycle.
//  - Handshake: rx_valid stays high and rx_data stays stable until accepted.
//    rx_valid falls the clock after rx_valid&&rx_ready, unless a new byte loads
//    in that same cycle.
//  - Byte completes and the register is empty, or rx_ready=1 in the same cycle:
//    the new byte loads and rx_valid=1.
//  - Byte completes with rx_valid=1 and rx_ready=0: the new byte is dropped, the
//    old byte is kept, and overrun pulses.
//  - Error pulses are registered and last exactly 1 clk.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - Frame is 8E1: a PARITY state samples a 9th bit, which must equal ^data (even).
//    - On mismatch the byte is still delivered; parity_err pulses in the same
//      cycle rx_valid rises (or with overrun if the byte is dropped).
//  UART_RX_PARITY_EN undefined:
//    - Frame is 8N1 and there is no PARITY state.
//    - parity_err is a constant 0.
// TESTING
//  - Clock 50MHz and BAUD 115200 (434 clk/bit) in every test.
//  - 8N1 0x55, rx_ready=1 -> rx_valid high exactly 1 clk, rx_data=0x55, no flags.
//  - uart_rxd low for 100 clk then high -> busy pulses, rx_valid stays 0, no flags.
//  - Frame 0xA3 with stop=0, then line high, then 0x3C ->
//    frame_err 1 pulse, 0xA3 never valid, 0x3C delivered.
//  - 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11 held, 1 overrun pulse.
//    Then rx_ready=1 for 1 clk -> rx_valid falls.
//  - sys_rst_n pulsed low during data bit 4 -> all outputs 0 at once.
//    Then full 0xF0 frame -> rx_data=0xF0.
//  - UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_data=0x07, parity_err pulses
//    with rx_valid rise. Same byte with parity bit 1 -> no parity_err.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// UART byte receiver: 2-flop synchronizer, 3-point majority bit sampling, valid/ready output.
// Optional even-parity (8E1) frame when UART_RX_PARITY_EN is defined; default is 8N1.
module uart_rx_frontend #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int TW      = $clog2(BIT_CNT);

  localparam logic [TW-1:0] T_LAST = TW'(BIT_CNT - 1);
  localparam logic [TW-1:0] T_S0   = TW'(HALF - 1);
  localparam logic [TW-1:0] T_S1   = TW'(HALF);
  localparam logic [TW-1:0] T_DEC  = TW'(HALF + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          sync1_reg, rxs_reg, rxs_prev_reg;
  logic          s0_reg, s1_reg;
  logic          decide, maj, byte_done, stop_bad;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_reg    <= 1'b1;
      rxs_reg      <= 1'b1;
      rxs_prev_reg <= 1'b1;
    end else begin
      sync1_reg    <= uart_rxd;
      rxs_reg      <= sync1_reg;
      rxs_prev_reg <= rxs_reg;
    end
  end

  // Two early samples are stored; the third is the live rxs at the decision cycle.
  assign decide = (timer_reg == T_DEC);
  assign maj    = (s0_reg & s1_reg) | (s0_reg & rxs_reg) | (s1_reg & rxs_reg);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      s0_reg      <= 1'b1;
      s1_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      if (timer_reg == T_S0) s0_reg <= rxs_reg;
      if (timer_reg == T_S1) s1_reg <= rxs_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_reg, par_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) par_reg <= 1'b0;
    else            par_reg <= par_next;
  end
`endif

  always_comb begin
    state_next   = state_reg;
    timer_next   = (timer_reg == T_LAST) ? '0 : timer_reg + TW'(1);
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    byte_done    = 1'b0;
    stop_bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next     = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (rxs_prev_reg && !rxs_reg) state_next = START;
      end
      START: begin
        if (decide) begin
          state_next   = maj ? IDLE : DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (decide) begin
          shift_next   = {maj, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide) begin
          par_next   = maj;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid-stop so a start bit right after the stop bit is not missed.
        if (decide) begin
          if (maj) begin
            byte_done  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = BRK;
          end
        end
      end
      BRK: begin
        timer_next = '0;
        if (rxs_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_done && rx_valid && !rx_ready;
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error is flagged whether the byte is loaded or dropped by overrun.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) parity_err <= 1'b0;
    else            parity_err <= byte_done && (par_reg != ^shift_reg);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed plus randomized bench for uart_rx_frontend at 50 MHz / 115200 baud.
// Builds with or without UART_RX_PARITY_EN; expectations follow the selected frame format.
module tb_uart_rx_frontend;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF     = BIT_CNT / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB     = 10;  // start + 8 data + parity before the stop bit
  localparam int PE_EXP = 1;
`else
  localparam int NB     = 9;
  localparam int PE_EXP = 0;
`endif
  // Line edge to rx_valid: 2 sync flops + edge detect, NB bits, mid-stop decision, output reg.
  localparam int LAT = 3 + NB * BIT_CNT + HALF + 2;

  logic       clk = 1'b0;
  logic       sys_rst_n, uart_rxd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, parity_err, busy;

  uart_rx_frontend #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .uart_rxd(uart_rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation counters, sampled on the falling edge.
  int         cyc = 0;
  int         valid_cyc = 0, fe_cyc = 0, ov_cyc = 0, pe_cyc = 0, busy_cyc = 0;
  int         rise_cyc = 0, pe_at_rise = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid)   valid_cyc++;
    if (frame_err)  fe_cyc++;
    if (overrun)    ov_cyc++;
    if (parity_err) pe_cyc++;
    if (busy)       busy_cyc++;
    if (rx_valid && !prev_valid) begin
      rise_cyc = cyc;
      if (parity_err) pe_at_rise++;
    end
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    prev_valid = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    tick(BIT_CNT);
  endtask

  // flip=1 sends the wrong even-parity bit (ignored in 8N1 builds).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {1'b1, stop, (^d) ^ flip, d, 1'b0};
`else
    bits = {1'b1, flip, stop, d, 1'b0};
`endif
    for (int i = 0; i <= NB; i++) send_bit(bits[i]);
    uart_rxd = 1'b1;
  endtask

  task automatic check_acc(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    check({tag, "_count"}, acc_q.size(), 1);
    got = (acc_q.size() > 0) ? acc_q.pop_front() : 8'hxx;
    check({tag, "_data"}, {24'd0, got}, {24'd0, exp});
    acc_q.delete();
  endtask

  initial begin
    int v0, fe0, ov0, pe0, pr0, b0, c0;
    logic [7:0] exp_q[$];
    logic [7:0] held, d;
    logic       hold_full, r, stop;
    int         fe_exp, ov_exp;

    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    rx_ready  = 1'b0;
    tick(5);
    check("rst_rx_data",    {24'd0, rx_data}, 0);
    check("rst_rx_valid",   rx_valid, 0);
    check("rst_frame_err",  frame_err, 0);
    check("rst_overrun",    overrun, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_busy",       busy, 0);
    sys_rst_n = 1'b1;
    tick(BIT_CNT);

    // 0x55 with consumer always ready.
    v0 = valid_cyc; fe0 = fe_cyc; ov0 = ov_cyc; pe0 = pe_cyc;
    rx_ready = 1'b1;
    c0 = cyc;
    send_frame(8'h55, 1'b1, 1'b0);
    tick(BIT_CNT);
    check_acc("b55", 8'h55);
    check("b55_valid_cycles", valid_cyc - v0, 1);
    check("b55_latency",      rise_cyc - c0, LAT);
    check("b55_no_flags",     (fe_cyc - fe0) + (ov_cyc - ov0) + (pe_cyc - pe0), 0);

    // False start: 100 clocks low is well short of the mid-bit sample point.
    v0 = valid_cyc; fe0 = fe_cyc; b0 = busy_cyc;
    uart_rxd = 1'b0;
    tick(100);
    uart_rxd = 1'b1;
    tick(2 * BIT_CNT);
    check("false_busy_pulsed", (busy_cyc - b0 > 100) && (busy_cyc - b0 < BIT_CNT), 1);
    check("false_busy_now",    busy, 0);
    check("false_no_valid",    valid_cyc - v0, 0);
    check("false_no_fe",       fe_cyc - fe0, 0);
    check("false_no_bytes",    acc_q.size(), 0);

    // Framing error on 0xA3, then a clean 0x3C.
    fe0 = fe_cyc;
    send_frame(8'hA3, 1'b0, 1'b0);
    tick(2 * BIT_CNT);
    check("ferr_pulse", fe_cyc - fe0, 1);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(BIT_CNT);
    check_acc("ferr_next", 8'h3C);

    // Back-to-back 0x11, 0x22 with consumer stalled.
    rx_ready = 1'b0;
    ov0 = ov_cyc;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(BIT_CNT);
    check("ovr_data_held", {24'd0, rx_data}, 32'h11);
    check("ovr_valid",     rx_valid, 1);
    check("ovr_pulse",     ov_cyc - ov0, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
    check("ovr_valid_fell", rx_valid, 0);
    check_acc("ovr_accept", 8'h11);

    // Reset during data bit 4 of 0xF0 while a byte is still held.
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(BIT_CNT);
    check("mrst_pre_valid", rx_valid, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    uart_rxd = 1'b1;
    tick(200);
    sys_rst_n = 1'b0;
    #1;
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_rx_data",  {24'd0, rx_data}, 0);
    check("mrst_busy",     busy, 0);
    check("mrst_flags",    {frame_err, overrun, parity_err}, 0);
    tick(3);
    sys_rst_n = 1'b1;
    tick(BIT_CNT);
    check("mrst_idle_after", {busy, rx_valid}, 0);
    send_frame(8'hF0, 1'b1, 1'b0);
    tick(BIT_CNT);
    check("mrst_f0_data",  {24'd0, rx_data}, 32'hF0);
    check("mrst_f0_valid", rx_valid, 1);
    rx_ready = 1'b1;
    tick(2);
    check_acc("mrst_f0_acc", 8'hF0);

    // 0x07 with wrong then correct parity bit (8N1 builds never flag parity).
    pe0 = pe_cyc; pr0 = pe_at_rise;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(BIT_CNT);
    check("par_bad_pulse",   pe_cyc - pe0, PE_EXP);
    check("par_bad_at_rise", pe_at_rise - pr0, PE_EXP);
    check_acc("par_bad_byte", 8'h07);
    pe0 = pe_cyc;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(BIT_CNT);
    check("par_good_none", pe_cyc - pe0, 0);
    check_acc("par_good_byte", 8'h07);

    // Random frames against a holding-register model of delivery, drop and overrun.
    fe0 = fe_cyc; ov0 = ov_cyc;
    fe_exp = 0; ov_exp = 0; hold_full = 1'b0; held = 8'h00;
    for (int k = 0; k < 5; k++) begin
      r    = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 4) != 0);
      d    = 8'($urandom);
      rx_ready = r;
      tick(1);
      if (r && hold_full) begin
        exp_q.push_back(held);
        hold_full = 1'b0;
      end
      send_frame(d, stop, 1'b0);
      tick($urandom_range(1, 2) * BIT_CNT);
      if (!stop)          fe_exp++;
      else if (r)         exp_q.push_back(d);
      else if (!hold_full) begin
        hold_full = 1'b1;
        held      = d;
      end else            ov_exp++;
    end
    rx_ready = 1'b1;
    tick(2);
    if (hold_full) exp_q.push_back(held);
    check("rnd_fe_count", fe_cyc - fe0, fe_exp);
    check("rnd_ov_count", ov_cyc - ov0, ov_exp);
    check("rnd_byte_count", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("rnd_byte%0d", i), (i < acc_q.size()) ? {24'd0, acc_q[i]} : 32'hxx,
            {24'd0, exp_q[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
